latch_write_sequencer: RTL

//  Clocked front-end stage that drives the en/d inputs of the level-sensitive d_latch.

---
 rtl/latch_write_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/latch_write_sequencer.sv
// Front-end sequencer driving the en/d pins of a level-sensitive latch.
// Each accepted 1-bit write runs SETUP -> OPEN -> HOLD with registered en/d.
module latch_write_sequencer #(
   parameter int SETUP_CYC = 1,
   parameter int OPEN_CYC  = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       req_data,
   output logic       req_ready,
   output logic       en,
   output logic       d,
   output logic       busy,
   output logic       done,
   output logic [7:0] wr_count
);

   localparam int MAX_SO  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
   localparam int MAX_CYC = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   if ((SETUP_CYC < 1) || (OPEN_CYC < 1) || (HOLD_CYC < 1)) begin : g_bad_param
      $error("latch_write_sequencer: SETUP_CYC, OPEN_CYC and HOLD_CYC must all be >= 1");
   end

   localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] OPEN_LOAD  = CW'(OPEN_CYC - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      OPEN  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;
   logic          en_s;
   logic          d_s;
   logic          done_s;
   logic          ready_s;
   logic [7:0]    wr_count_s;
   logic          accept_s;

   // Next-state and next-output decode; the last HOLD cycle may chain straight into a new write
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      en_s       = en;
      d_s        = d;
      done_s     = 1'b0;
      ready_s    = req_ready;
      wr_count_s = wr_count;
      accept_s   = 1'b0;

      case (state_r)
         IDLE: begin
            en_s = 1'b0;
            if (req_valid) begin
               accept_s = 1'b1;
            end else begin
               ready_s = 1'b1;
            end
         end
         SETUP: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = OPEN;
               cnt_s   = OPEN_LOAD;
               en_s    = 1'b1;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         OPEN: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = HOLD;
               cnt_s   = HOLD_LOAD;
               en_s    = 1'b0;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         HOLD: begin
            if (cnt_r == CNT_ZERO) begin
               done_s     = 1'b1;
               wr_count_s = wr_count + 8'd1;
               if (req_valid) begin
                  accept_s = 1'b1;
               end else begin
                  state_s = IDLE;
                  ready_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            en_s    = 1'b0;
            ready_s = 1'b1;
         end
      endcase

      // d is only ever loaded here, so it cannot move while the latch is being driven
      if (accept_s) begin
         state_s = SETUP;
         cnt_s   = SETUP_LOAD;
         d_s     = req_data;
         ready_s = 1'b0;
      end else begin
         d_s = d;
      end
   end

   // State, counter and all outputs registered; reset abandons any sequence in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         en        <= 1'b0;
         d         <= 1'b0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_count  <= 8'd0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         en        <= en_s;
         d         <= d_s;
         req_ready <= ready_s;
         busy      <= ~ready_s;
         done      <= done_s;
         wr_count  <= wr_count_s;
      end
   end

endmodule
